// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC frame unpacker.
package adc_pkg;

   localparam int ADC_NUM_CH   = 8;
   localparam int ADC_SAMPLE_W = 16;
   localparam int ADC_FRAME_W  = ADC_NUM_CH * ADC_SAMPLE_W;
   localparam int ADC_CHAN_W   = $clog2(ADC_NUM_CH);

   // Drain FSM: IDLE has nothing to present, DRAIN presents the head frame.
   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } adc_unpack_state_t;

   // Channel index within a frame.
   typedef logic [ADC_CHAN_W-1:0] adc_chan_t;

endpackage

// File: rtl/adc_frame_buf.sv
// Two-entry frame FIFO. The head and the entry behind it are both visible
// so the consumer can switch frames without a bubble. When full, a write
// in the same cycle as a pop lands in the slot being freed.
module adc_frame_buf
   import adc_pkg::*;
#(
   parameter int W = ADC_FRAME_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_data_o,
   output logic [W-1:0] next_data_o,
   output logic [1:0]   count_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;

   // Frame storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointer and occupancy next-state; the caller never overfills or underflows.
   always_comb begin
      wr_ptr_d = wr_ptr_q ^ wr_en_i;
      rd_ptr_d = rd_ptr_q ^ pop_i;
      count_d  = count_q + {1'b0, wr_en_i} - {1'b0, pop_i};
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data_o = mem_q[rd_ptr_q];
   assign next_data_o = mem_q[~rd_ptr_q];
   assign count_o     = count_q;
   assign full_o      = (count_q == 2'd2);
   assign empty_o     = (count_q == 2'd0);

endmodule

// File: rtl/adc_frame_unpacker.sv
// Splits 128-bit ADC frames into a valid/ready stream of per-channel samples.
// Channel 0 is the MSB slice of the frame. A two-entry buffer absorbs frames
// while the consumer stalls; frames arriving into a full buffer are dropped
// and flagged on the sticky overflow output.
// Build option: define ADC_UNPACK_TWOS_EN to invert each sample MSB
// (offset-binary to two's complement). Timing is the same either way.
module adc_frame_unpacker
   import adc_pkg::*;
#(
   parameter  int NUM_CH   = ADC_NUM_CH,
   parameter  int SAMPLE_W = ADC_SAMPLE_W,
   localparam int FRAME_W  = NUM_CH * SAMPLE_W,
   localparam int CHAN_W   = $clog2(NUM_CH)
) (
   input  logic                SCLK,
   input  logic                RST,
   input  logic [FRAME_W-1:0]  serial_read,
   input  logic                frame_valid,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic [CHAN_W-1:0]   sample_chan,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                sample_last,
   output logic                overflow,
   input  logic                ovf_clr,
   output logic [15:0]         frame_count
);

   localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(NUM_CH - 1);

`ifdef ADC_UNPACK_TWOS_EN
   localparam logic [SAMPLE_W-1:0] FMT_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};
`else
   localparam logic [SAMPLE_W-1:0] FMT_MASK = '0;
`endif

   adc_unpack_state_t   state_q, state_d;
   logic [CHAN_W-1:0]   chan_q, chan_d;
   logic [SAMPLE_W-1:0] data_q, data_d;
   logic                last_q, last_d;
   logic                ovf_q, ovf_d;
   logic [15:0]         fcnt_q, fcnt_d;

   logic                xfer;
   logic                load;
   logic                sel_next;
   logic                sel_in;
   logic                buf_wr;
   logic                buf_pop;
   logic                drop;
   logic [FRAME_W-1:0]  head_frame;
   logic [FRAME_W-1:0]  next_frame;
   logic [FRAME_W-1:0]  src_frame;
   logic [1:0]          buf_count;
   logic                buf_full;
   logic                buf_empty;
   logic [SAMPLE_W-1:0] src_slice [NUM_CH];

   // A transfer of the last channel frees the head slot in the same cycle,
   // so a full buffer can still take a frame then.
   assign xfer    = (state_q == DRAIN) && sample_ready;
   assign buf_pop = xfer && (chan_q == LAST_CH);
   assign buf_wr  = frame_valid && (!buf_full || buf_pop);
   assign drop    = frame_valid && !buf_wr;

   adc_frame_buf #(
      .W (FRAME_W)
   ) u_buf (
      .clk         (SCLK),
      .rst         (RST),
      .wr_en_i     (buf_wr),
      .wr_data_i   (serial_read),
      .pop_i       (buf_pop),
      .head_data_o (head_frame),
      .next_data_o (next_frame),
      .count_o     (buf_count),
      .full_o      (buf_full),
      .empty_o     (buf_empty)
   );

   // Drain FSM: picks the next state, next channel and which frame feeds the output register.
   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      load     = 1'b0;
      sel_next = 1'b0;
      sel_in   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!buf_empty) begin
               state_d = DRAIN;
               chan_d  = '0;
               load    = 1'b1;
            end
         end
         DRAIN: begin
            if (xfer) begin
               if (chan_q == LAST_CH) begin
                  chan_d = '0;
                  if (buf_count > 2'd1) begin
                     // Second buffered frame becomes the head with no bubble.
                     sel_next = 1'b1;
                     load     = 1'b1;
                  end else if (buf_wr) begin
                     // Sole frame pops while a new one arrives: present it directly.
                     sel_in = 1'b1;
                     load   = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  chan_d = chan_q + 1'b1;
                  load   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign src_frame = sel_next ? next_frame :
                      sel_in   ? serial_read : head_frame;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
         assign src_slice[gi] = src_frame[FRAME_W-1-gi*SAMPLE_W -: SAMPLE_W];
      end
   endgenerate

   // Output register next-state: reload on a new channel, otherwise hold.
   always_comb begin
      data_d = data_q;
      last_d = last_q;
      if (load) begin
         data_d = src_slice[chan_d] ^ FMT_MASK;
         last_d = (chan_d == LAST_CH);
      end else if (state_d == IDLE) begin
         last_d = 1'b0;
      end
   end

   // Sticky overflow (a drop beats a clear) and accepted-frame counter.
   always_comb begin
      ovf_d  = drop || (ovf_q && !ovf_clr);
      fcnt_d = fcnt_q + {15'd0, buf_wr};
   end

   // State and output registers.
   always_ff @(posedge SCLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         chan_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign sample_valid = (state_q == DRAIN);
   assign sample_data  = data_q;
   assign sample_chan  = chan_q;
   assign sample_last  = last_q;
   assign overflow     = ovf_q;
   assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_adc_frame_unpacker.sv
// Directed bench for adc_frame_unpacker: a per-cycle vector table for the
// basic drain patterns, then hand-written multi-cycle corner sequences.
module tb_adc_frame_unpacker;
   import adc_pkg::*;

   localparam int NCH = ADC_NUM_CH;
   localparam int SW  = ADC_SAMPLE_W;
   localparam int FW  = ADC_FRAME_W;

   logic          SCLK = 1'b0;
   logic          RST;
   logic [FW-1:0] serial_read;
   logic          frame_valid;
   logic [SW-1:0] sample_data;
   adc_chan_t     sample_chan;
   logic          sample_valid;
   logic          sample_ready;
   logic          sample_last;
   logic          overflow;
   logic          ovf_clr;
   logic [15:0]   frame_count;

   always #5 SCLK = ~SCLK;

   adc_frame_unpacker dut (
      .SCLK         (SCLK),
      .RST          (RST),
      .serial_read  (serial_read),
      .frame_valid  (frame_valid),
      .sample_data  (sample_data),
      .sample_chan  (sample_chan),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_last  (sample_last),
      .overflow     (overflow),
      .ovf_clr      (ovf_clr),
      .frame_count  (frame_count)
   );

   typedef struct {
      logic          fv;
      logic [FW-1:0] frame;
      logic          rdy;
      logic          clr;
      logic          e_valid;
      logic [SW-1:0] e_data;
      logic [2:0]    e_chan;
      logic          e_last;
      logic          e_ovf;
      logic [15:0]   e_fc;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Expected output format for a raw sample.
   function automatic logic [SW-1:0] xf(input logic [SW-1:0] d);
`ifdef ADC_UNPACK_TWOS_EN
      return d ^ {1'b1, {(SW-1){1'b0}}};
`else
      return d;
`endif
   endfunction

   // Frame whose channel k holds base + k*stp (channel 0 in the MSB slice).
   function automatic logic [FW-1:0] mk(input logic [SW-1:0] base, input logic [SW-1:0] stp);
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < NCH; k++) begin
         f[FW-1-k*SW -: SW] = base + stp * SW'(k);
      end
      return f;
   endfunction

   task automatic step();
      @(posedge SCLK);
      #1;
   endtask

   task automatic expect_sample(input string nm, input logic [SW-1:0] d, input int ch);
      check({nm, " valid"}, 32'(sample_valid), 32'd1);
      check({nm, " data"}, 32'(sample_data), 32'(xf(d)));
      check({nm, " chan"}, 32'(sample_chan), 32'(ch));
      check({nm, " last"}, 32'(sample_last), (ch == NCH - 1) ? 32'd1 : 32'd0);
   endtask

   // One frame strobed into an idle block then drained, either with ready
   // held high or with ready alternating 0,1,0,1 from the first presented sample.
   task automatic push_drain(input logic [SW-1:0] base, input logic [SW-1:0] stp,
                             input bit toggle, input logic [15:0] fc);
      vec_t v;
      int   n;
      int   ch;
      n = toggle ? 17 : 10;
      for (int i = 0; i < n; i++) begin
         v.fv    = (i == 0);
         v.frame = mk(base, stp);
         v.clr   = 1'b0;
         v.e_ovf = 1'b0;
         v.e_fc  = fc;
         if (toggle) begin
            v.rdy = (i >= 1) && (i % 2 == 0);
            ch    = i / 2;
         end else begin
            v.rdy = 1'b1;
            ch    = i - 1;
         end
         v.e_valid = (i >= 1) && (i < n - 1);
         v.e_chan  = 3'(ch);
         v.e_data  = xf(base + stp * SW'(ch));
         v.e_last  = (ch == NCH - 1);
         vecs.push_back(v);
      end
   endtask

   initial begin
      RST          = 1'b1;
      serial_read  = '0;
      frame_valid  = 1'b0;
      sample_ready = 1'b0;
      ovf_clr      = 1'b0;

      // Build the vector table.
      push_drain(16'h0001, 16'h0001, 1'b0, 16'd1);
      push_drain(16'h0001, 16'h0001, 1'b1, 16'd2);
      push_drain(16'h8000, 16'h0000, 1'b0, 16'd3);
      push_drain(16'h7FFF, 16'h0000, 1'b0, 16'd4);

      // Reset values.
      repeat (2) step();
      check("rst valid", 32'(sample_valid), 32'd0);
      check("rst data", 32'(sample_data), 32'd0);
      check("rst chan", 32'(sample_chan), 32'd0);
      check("rst last", 32'(sample_last), 32'd0);
      check("rst ovf", 32'(overflow), 32'd0);
      check("rst fc", 32'(frame_count), 32'd0);
      RST = 1'b0;
      step();

      // Table-driven drains.
      foreach (vecs[i]) begin
         frame_valid  = vecs[i].fv;
         serial_read  = vecs[i].frame;
         sample_ready = vecs[i].rdy;
         ovf_clr      = vecs[i].clr;
         step();
         check($sformatf("v%0d valid", i), 32'(sample_valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            check($sformatf("v%0d data", i), 32'(sample_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d chan", i), 32'(sample_chan), 32'(vecs[i].e_chan));
            check($sformatf("v%0d last", i), 32'(sample_last), 32'(vecs[i].e_last));
         end
         check($sformatf("v%0d ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
         check($sformatf("v%0d fc", i), 32'(frame_count), 32'(vecs[i].e_fc));
      end
      frame_valid = 1'b0;

      // Stalled consumer: A and B buffered, C dropped, then A,B back to back.
      sample_ready = 1'b0;
      frame_valid = 1'b1; serial_read = mk(16'h1A00, 16'h0001); step(); frame_valid = 1'b0;
      repeat (9) step();
      check("ovf after A", 32'(overflow), 32'd0);
      frame_valid = 1'b1; serial_read = mk(16'h2B00, 16'h0001); step(); frame_valid = 1'b0;
      repeat (9) step();
      check("ovf after B", 32'(overflow), 32'd0);
      frame_valid = 1'b1; serial_read = mk(16'h3C00, 16'h0001); step(); frame_valid = 1'b0;
      check("ovf after C", 32'(overflow), 32'd1);
      check("fc after ABC", 32'(frame_count), 32'd6);
      expect_sample("stall A0", 16'h1A00, 0);
      step();
      expect_sample("hold A0", 16'h1A00, 0);
      sample_ready = 1'b1;
      for (int j = 0; j < 2 * NCH; j++) begin
         expect_sample($sformatf("AB%0d", j),
                       (j < NCH) ? 16'h1A00 + 16'(j) : 16'h2B00 + 16'(j - NCH), j % NCH);
         step();
      end
      check("AB idle", 32'(sample_valid), 32'd0);
      check("ovf sticky", 32'(overflow), 32'd1);
      sample_ready = 1'b0; ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      check("ovf clr", 32'(overflow), 32'd0);

      // Full buffer with head chan-7 transfer coinciding with a new frame.
      frame_valid = 1'b1; serial_read = mk(16'h4000, 16'h0001); step(); frame_valid = 1'b0;
      step();
      frame_valid = 1'b1; serial_read = mk(16'h5000, 16'h0001); step(); frame_valid = 1'b0;
      step();
      check("fc after PQ", 32'(frame_count), 32'd8);
      expect_sample("P0", 16'h4000, 0);
      sample_ready = 1'b1;
      repeat (NCH - 1) step();
      expect_sample("P7", 16'h4007, NCH - 1);
      frame_valid = 1'b1; serial_read = mk(16'h6000, 16'h0001); step(); frame_valid = 1'b0;
      check("ovf simul", 32'(overflow), 32'd0);
      check("fc simul", 32'(frame_count), 32'd9);
      for (int j = 0; j < 2 * NCH; j++) begin
         expect_sample($sformatf("QR%0d", j),
                       (j < NCH) ? 16'h5000 + 16'(j) : 16'h6000 + 16'(j - NCH), j % NCH);
         step();
      end
      check("QR idle", 32'(sample_valid), 32'd0);

      // Clear coincident with a drop: the drop wins.
      sample_ready = 1'b0;
      frame_valid = 1'b1; serial_read = mk(16'h7000, 16'h0001); step(); frame_valid = 1'b0;
      step();
      frame_valid = 1'b1; serial_read = mk(16'h7100, 16'h0001); step(); frame_valid = 1'b0;
      step();
      frame_valid = 1'b1; serial_read = mk(16'h7200, 16'h0001); ovf_clr = 1'b1; step();
      frame_valid = 1'b0; ovf_clr = 1'b0;
      check("ovf clr+drop", 32'(overflow), 32'd1);
      check("fc clr+drop", 32'(frame_count), 32'd11);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      check("ovf clr alone", 32'(overflow), 32'd0);
      sample_ready = 1'b1;
      for (int j = 0; j < 2 * NCH; j++) begin
         expect_sample($sformatf("T%0d", j),
                       (j < NCH) ? 16'h7000 + 16'(j) : 16'h7100 + 16'(j - NCH), j % NCH);
         step();
      end
      check("T idle", 32'(sample_valid), 32'd0);

      // Asynchronous reset while chan 3 is presented.
      frame_valid = 1'b1; serial_read = mk(16'h9000, 16'h0001); step(); frame_valid = 1'b0;
      repeat (4) step();
      expect_sample("F3", 16'h9003, 3);
      #2 RST = 1'b1;
      #1;
      check("arst valid", 32'(sample_valid), 32'd0);
      check("arst data", 32'(sample_data), 32'd0);
      check("arst chan", 32'(sample_chan), 32'd0);
      check("arst last", 32'(sample_last), 32'd0);
      check("arst fc", 32'(frame_count), 32'd0);
      step();
      RST = 1'b0;
      step();
      check("post rst idle", 32'(sample_valid), 32'd0);
      frame_valid = 1'b1; serial_read = mk(16'hA000, 16'h0001); step(); frame_valid = 1'b0;
      check("G latency", 32'(sample_valid), 32'd0);
      check("G fc", 32'(frame_count), 32'd1);
      step();
      expect_sample("G0", 16'hA000, 0);
      step();
      expect_sample("G1", 16'hA001, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_frame_unpacker.md
# adc_frame_unpacker

Consumes the 128-bit parallel frame produced by `ADC_SPI_INTERFACE` on `serial_read` and emits it as a stream of per-channel 16-bit samples using a valid/ready handshake. A two-entry frame buffer decouples the SPI frame rate from the downstream consumer. Frame drops are reported through a sticky overflow flag. The block sits between the ADC SPI front end and the sample-processing datapath, in the same `SCLK` domain.

## Interface
Parameters:
- `NUM_CH`, 8: channels per frame.
- `SAMPLE_W`, 16: bits per channel sample.
- `FRAME_W`, `NUM_CH*SAMPLE_W` (128): frame width. Derived; do not override.

Ports:
- `SCLK`  in  1: sole clock, rising edge.
- `RST`  in  1: reset, asynchronous and active-high.
- `serial_read`  in  `FRAME_W`: frame from the SPI interface. Sampled only when `frame_valid`=1.
- `frame_valid`  in  1: one-cycle strobe marking a complete frame.
- `sample_data`  out  `SAMPLE_W`: current sample.
- `sample_chan`  out  `$clog2(NUM_CH)` (3): channel index of `sample_data`.
- `sample_valid`  out  1: `sample_data` and `sample_chan` are valid.
- `sample_ready`  in  1: consumer accepts the sample. A transfer occurs when `sample_valid`=1 and `sample_ready`=1 at a `SCLK` rising edge.
- `sample_last`  out  1: high with the sample whose `sample_chan`=`NUM_CH-1`.
- `overflow`  out  1: sticky. Set when a frame is dropped.
- `ovf_clr`  in  1: synchronous clear of `overflow`.
- `frame_count`  out  16: number of frames accepted. Wraps from 0xFFFF to 0.

## Operation
- Channel mapping: channel k = `serial_read[FRAME_W-1-k*SAMPLE_W -: SAMPLE_W]`. Channel 0 is the MSB slice, i.e. the first bits shifted in.
- Frame buffer:
  - Two entries, FIFO order, occupancy 0..2.
  - A frame with `frame_valid`=1 is written if occupancy < 2, or if occupancy = 2 and the head's last sample transfers in the same cycle. In that case the freed slot is reused in that cycle.
  - Otherwise the frame is dropped and `overflow` is set.
  - `frame_count` increments only on accepted frames.
- State machine:
  - IDLE: `sample_valid`=0. Moves to DRAIN when occupancy becomes nonzero.
  - DRAIN: presents head-frame channel `chan_idx`.
    - On each transfer, `chan_idx` increments.
    - On transfer at `NUM_CH-1`: the head frame pops and `chan_idx` returns to 0. The block stays in DRAIN if another frame is buffered, otherwise returns to IDLE.
- Holding: while `sample_valid`=1 and `sample_ready`=0, all of `sample_data`, `sample_chan` and `sample_last` hold stable.
- Overflow register:
  - `ovf_clr` and a drop in the same cycle: `overflow` ends at 1 (set wins).
  - `ovf_clr` alone: `overflow` ends at 0.
- Reset mid-frame: occupancy goes to 0, the state goes to IDLE, and any partially drained frame is discarded with no notification.

## Timing
- Reset values: `sample_valid`=0, `sample_data`=0, `sample_chan`=0, `sample_last`=0, `overflow`=0, `frame_count`=0, internal state = IDLE.
- Latency: `frame_valid` at edge N into an empty block gives `sample_valid`=1 with channel 0 after edge N+1.
- Throughput: one sample per cycle while `sample_ready`=1. The next buffered frame's channel 0 follows the previous frame's channel 7 with no bubble.
- All outputs are driven from registers. There is no combinational path from `sample_ready` to any output.
- `frame_valid` pulses are at least one cycle apart. The SPI interface delivers a frame every ≥128 `SCLK` cycles.

## Configuration
- `ADC_UNPACK_TWOS_EN` defined: each sample's MSB is inverted on output, converting ADC offset-binary to two's complement. Examples: 0x8000→0x0000, 0x0000→0x8000.
- `ADC_UNPACK_TWOS_EN` undefined: samples pass through unchanged.
- The macro affects only `sample_data`. Timing is identical in both builds.

## Structure
- Package `adc_pkg` holds:
  - Constants `ADC_NUM_CH`, `ADC_SAMPLE_W` and `ADC_FRAME_W`.
  - The state enum `adc_unpack_state_t` with values IDLE and DRAIN.
  - The channel-index typedef.
- Sub-module `adc_frame_buf` is the two-entry frame FIFO. It provides write, pop, head data, occupancy, and full/empty outputs.
- The top level contains the drain FSM, the output register, the overflow logic and the frame counter.

## Test plan
- Single frame 0x0001_0002_..._0008, `sample_ready`=1 throughout → 8 consecutive transfers with chan 0..7 and data 0x0001..0x0008; `sample_last` only on chan 7; `frame_count`=1.
- Same frame with `sample_ready` toggling 1,0,1,0 → data and chan held during stalls; same ordered 8 samples delivered.
- `sample_ready`=0 and three frames A, B, C strobed 10 cycles apart → A and B buffered, C dropped, `overflow`=1, `frame_count`=2; after releasing `sample_ready`, 16 samples arrive (A then B) with no bubble between them.
- Occupancy 2 with the head's chan-7 transfer in the same cycle as `frame_valid` → frame accepted, no overflow; `ovf_clr` coincident with a drop → `overflow` remains 1.
- `RST` asserted while delivering chan 3 → all outputs reset asynchronously; after release, the next frame starts at chan 0.
- Build with `ADC_UNPACK_TWOS_EN`, frame of all 0x8000 → all samples read 0x0000; frame of all 0x7FFF → all samples read 0xFFFF.
